// File: rtl/xml_lang_dispatch_pkg.sv
// Shared types and defaults for the xmlCheckLanguageID call sequencer.
package xml_lang_pkg;

  localparam int unsigned PTR_W_DEF = 64;
  localparam int unsigned RES_W_DEF = 32;
  localparam int unsigned STAT_W    = 32;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    ACK
  } state_t;

endpackage

// File: rtl/xml_lang_dispatch_if.sv
// Request / component-call / response / flush signal bundle for xml_lang_dispatch.
interface xml_lang_dispatch_if #(
  parameter int unsigned PTR_W = xml_lang_pkg::PTR_W_DEF,
  parameter int unsigned RES_W = xml_lang_pkg::RES_W_DEF
);

  logic             req_valid;
  logic             req_ready;
  logic [PTR_W-1:0] req_ptr;
  logic             comp_start;
  logic             comp_busy;
  logic [PTR_W-1:0] comp_lang;
  logic             comp_done;
  logic             comp_stall;
  logic [RES_W-1:0] comp_result;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [RES_W-1:0] rsp_data;
  logic [PTR_W-1:0] rsp_ptr;
  logic             flush_req;
  logic             flush_ack;
  logic             err;

  // Environment side: request source, component model, response sink.
  modport master (
    output req_valid, req_ptr, comp_busy, comp_done, comp_result, rsp_ready, flush_req,
    input  req_ready, comp_start, comp_lang, comp_stall, rsp_valid, rsp_data, rsp_ptr,
           flush_ack, err
  );

  modport slave (
    input  req_valid, req_ptr, comp_busy, comp_done, comp_result, rsp_ready, flush_req,
    output req_ready, comp_start, comp_lang, comp_stall, rsp_valid, rsp_data, rsp_ptr,
           flush_ack, err
  );

endinterface

// File: rtl/xml_lang_ptr_fifo.sv
// In-order pointer FIFO; indices carry one extra wrap bit so full/empty need no counter.
module xml_lang_ptr_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 64
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_idx;
  logic [AW:0]  rd_idx;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_idx == rd_idx);
  assign full    = ((wr_idx ^ rd_idx) == {1'b1, {AW{1'b0}}});
  assign count   = wr_idx - rd_idx;
  assign head    = mem[rd_idx[AW-1:0]];
  assign do_pop  = pop && !empty;
  // A push while full is only safe when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_idx <= '0;
      rd_idx <= '0;
    end else begin
      if (do_push) wr_idx <= wr_idx + 1'b1;
      if (do_pop)  rd_idx <= rd_idx + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_idx[AW-1:0]] <= din;
  end

endmodule

// File: rtl/xml_lang_dispatch.sv
// Call sequencer for xmlCheckLanguageID: issues calls, tags results with their pointer, drains on flush.
// Define XML_LANG_DISPATCH_STATS_EN to add the stat_calls / stat_valid counters.
module xml_lang_dispatch
  import xml_lang_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = PTR_W_DEF,
  parameter int unsigned RES_W = RES_W_DEF
) (
  input  logic                clock,
  input  logic                resetn,
  xml_lang_dispatch_if.slave  bus
`ifdef XML_LANG_DISPATCH_STATS_EN
  ,
  output logic [STAT_W-1:0]   stat_calls,
  output logic [STAT_W-1:0]   stat_valid
`endif
);

  state_t state;
  state_t state_next;

  logic                    issue_en;
  logic                    can_issue;
  logic                    accept;
  logic                    capture;
  logic                    stall;
  logic [PTR_W-1:0]        head;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [$clog2(DEPTH):0]  inflight;
  logic                    rsp_valid;
  logic [RES_W-1:0]        rsp_data;
  logic [PTR_W-1:0]        rsp_ptr;
  logic                    err;
  logic                    flush_ack;

  xml_lang_ptr_fifo #(
    .DEPTH (DEPTH),
    .W     (PTR_W)
  ) u_fifo (
    .clock  (clock),
    .resetn (resetn),
    .push   (accept),
    .pop    (capture),
    .din    (bus.req_ptr),
    .head   (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (inflight)
  );

  // Issue path; gating with resetn keeps the handshake outputs low while reset is held.
  assign can_issue      = issue_en && !fifo_full && resetn;
  assign bus.comp_lang  = bus.req_ptr;
  assign bus.comp_start = bus.req_valid && can_issue;
  assign bus.req_ready  = can_issue && !bus.comp_busy;
  assign accept         = bus.req_valid && bus.req_ready;

  assign stall          = rsp_valid && !bus.rsp_ready;
  assign bus.comp_stall = stall;
  assign capture        = bus.comp_done && !stall;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= RUN;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      RUN:     if (bus.flush_req) state_next = DRAIN;
      DRAIN:   if (inflight == '0 && !rsp_valid) state_next = ACK;
      ACK:     state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    issue_en  = (state == RUN);
    flush_ack = (state == ACK);
  end

  // A capture with nothing outstanding is still delivered, tagged with a null pointer.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_ptr   <= '0;
      err       <= 1'b0;
    end else if (capture) begin
      rsp_valid <= 1'b1;
      rsp_data  <= bus.comp_result;
      rsp_ptr   <= fifo_empty ? '0 : head;
      if (fifo_empty) err <= 1'b1;
    end else if (bus.rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = rsp_data;
  assign bus.rsp_ptr   = rsp_ptr;
  assign bus.err       = err;
  assign bus.flush_ack = flush_ack;

`ifdef XML_LANG_DISPATCH_STATS_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stat_calls <= '0;
      stat_valid <= '0;
    end else begin
      if (accept) stat_calls <= stat_calls + 1'b1;
      if (capture && bus.comp_result != '0) stat_valid <= stat_valid + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_xml_lang_dispatch.sv
// Self-checking bench for xml_lang_dispatch against a queue-based transaction model.
module tb_xml_lang_dispatch;

  localparam int unsigned DEPTH = 4;

  logic clock;
  logic resetn;

  xml_lang_dispatch_if #(.PTR_W(64), .RES_W(32)) bus ();

`ifdef XML_LANG_DISPATCH_STATS_EN
  logic [31:0] stat_calls;
  logic [31:0] stat_valid;
`endif

  xml_lang_dispatch #(
    .DEPTH (DEPTH),
    .PTR_W (64),
    .RES_W (32)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
`ifdef XML_LANG_DISPATCH_STATS_EN
    ,
    .stat_calls (stat_calls),
    .stat_valid (stat_valid)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model: outstanding pointers, held response, flush progress.
  logic [63:0] ptr_q[$];
  bit          m_rv, m_err, m_drain, m_ack;
  logic [31:0] m_rd;
  logic [63:0] m_rp;
  logic [31:0] m_calls, m_valid;
  bit          e_ready, e_start, e_stall;

  task automatic model_reset();
    ptr_q.delete();
    m_rv = 0; m_err = 0; m_drain = 0; m_ack = 0;
    m_rd = '0; m_rp = '0; m_calls = '0; m_valid = '0;
  endtask

  task automatic model_comb();
    bit running;
    running = !m_drain && !m_ack && resetn && (ptr_q.size() < DEPTH);
    e_start = bus.req_valid && running;
    e_ready = running && !bus.comp_busy;
    e_stall = m_rv && !bus.rsp_ready;
  endtask

  task automatic advance();
    bit acc, cap, was_empty, was_rv;
    model_comb();
    acc       = bus.req_valid && e_ready;
    cap       = bus.comp_done && !e_stall;
    was_empty = (ptr_q.size() == 0);
    was_rv    = m_rv;
    @(posedge clock);
    if (m_ack) m_ack = 0;
    else if (m_drain) begin
      if (was_empty && !was_rv) begin m_drain = 0; m_ack = 1; end
    end else if (bus.flush_req) m_drain = 1;
    if (cap) begin
      if (was_empty) begin m_err = 1; m_rp = '0; end
      else m_rp = ptr_q.pop_front();
      m_rd = bus.comp_result;
      m_rv = 1;
      if (bus.comp_result != 0) m_valid = m_valid + 1;
    end else if (bus.rsp_ready) m_rv = 0;
    if (acc) begin
      ptr_q.push_back(bus.req_ptr);
      m_calls = m_calls + 1;
    end
    #1;
  endtask

  task automatic set_idle();
    bus.req_valid = 0; bus.req_ptr = '0; bus.comp_busy = 0; bus.comp_done = 0;
    bus.comp_result = '0; bus.rsp_ready = 1; bus.flush_req = 0;
  endtask

  task automatic test_reset();
    set_idle();
    bus.req_valid = 1; bus.rsp_ready = 0;
    resetn = 0;
    model_reset();
    #12;
    n_vec++;
    if ({bus.req_ready, bus.comp_start, bus.comp_stall, bus.rsp_valid, bus.flush_ack, bus.err} !== 6'b0
        || bus.rsp_data !== 32'd0 || bus.rsp_ptr !== 64'd0) begin
      n_err++;
      $display("FAIL reset_values: rdy=%b start=%b stall=%b rv=%b ack=%b err=%b data=%h ptr=%h, all zero required",
               bus.req_ready, bus.comp_start, bus.comp_stall, bus.rsp_valid, bus.flush_ack, bus.err,
               bus.rsp_data, bus.rsp_ptr);
    end
`ifdef XML_LANG_DISPATCH_STATS_EN
    n_vec++;
    if (stat_calls !== 32'd0 || stat_valid !== 32'd0) begin
      n_err++;
      $display("FAIL reset_stats: calls=%0d valid=%0d, 0/0 required", stat_calls, stat_valid);
    end
`endif
    set_idle();
    resetn = 1;
    advance();
  endtask

  task automatic test_single_call();
    bus.req_valid = 1; bus.req_ptr = 64'h1000;
    #1;
    n_vec++;
    if (bus.comp_start !== 1'b1 || bus.req_ready !== 1'b1 || bus.comp_lang !== 64'h1000) begin
      n_err++;
      $display("FAIL single_issue: start=%b rdy=%b lang=%h, 1/1/1000 required",
               bus.comp_start, bus.req_ready, bus.comp_lang);
    end
    advance();
    bus.req_valid = 0;
    repeat (4) advance();
    bus.comp_done = 1; bus.comp_result = 32'd1;
    advance();
    bus.comp_done = 0;
    n_vec++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'd1 || bus.rsp_ptr !== 64'h1000) begin
      n_err++;
      $display("FAIL single_rsp: rv=%b data=%h ptr=%h, 1/1/1000 required",
               bus.rsp_valid, bus.rsp_data, bus.rsp_ptr);
    end
    advance();
    n_vec++;
    if (bus.rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_clear: rv=%b, 0 required", bus.rsp_valid);
    end
  endtask

  task automatic test_ordering();
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      bus.req_valid = 1; bus.req_ptr = 64'((i + 1) * 16);
      advance();
    end
    bus.req_ptr = 64'h50;
    #1;
    n_vec++;
    if (bus.req_ready !== 1'b0) begin
      n_err++;
      $display("FAIL order_full_block: rdy=%b, 0 required", bus.req_ready);
    end
    for (int i = 0; i < 5; i++) begin
      res = (i % 2 == 0) ? 32'd1 : 32'd0;
      bus.comp_done = 1; bus.comp_result = res;
      #1;
      if (i < 2) begin
        n_vec++;
        if (bus.req_ready !== (i == 1)) begin
          n_err++;
          $display("FAIL order_ready_%0d: rdy=%b, %b required", i, bus.req_ready, i == 1);
        end
      end
      advance();
      if (i == 1) bus.req_valid = 0;
      n_vec++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== res || bus.rsp_ptr !== 64'((i + 1) * 16)) begin
        n_err++;
        $display("FAIL order_rsp_%0d: rv=%b data=%h ptr=%h, 1/%h/%h required",
                 i, bus.rsp_valid, bus.rsp_data, bus.rsp_ptr, res, 64'((i + 1) * 16));
      end
    end
    bus.comp_done = 0;
    advance();
  endtask

  task automatic test_backpressure();
    bus.rsp_ready = 0;
    bus.req_valid = 1; bus.req_ptr = 64'hA0; advance();
    bus.req_ptr = 64'hB0; advance();
    bus.req_valid = 0;
    bus.comp_done = 1; bus.comp_result = 32'd7; advance();
    bus.comp_result = 32'd9;
    #1;
    n_vec++;
    if (bus.comp_stall !== 1'b1) begin
      n_err++;
      $display("FAIL bp_stall: stall=%b, 1 required", bus.comp_stall);
    end
    advance();
    n_vec++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'd7 || bus.rsp_ptr !== 64'hA0) begin
      n_err++;
      $display("FAIL bp_hold: rv=%b data=%h ptr=%h, 1/7/a0 required", bus.rsp_valid, bus.rsp_data, bus.rsp_ptr);
    end
    bus.rsp_ready = 1;
    advance();
    bus.comp_done = 0;
    n_vec++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'd9 || bus.rsp_ptr !== 64'hB0) begin
      n_err++;
      $display("FAIL bp_second: rv=%b data=%h ptr=%h, 1/9/b0 required", bus.rsp_valid, bus.rsp_data, bus.rsp_ptr);
    end
    advance();
  endtask

  task automatic test_flush();
    bus.req_valid = 1; bus.req_ptr = 64'hC0; advance();
    bus.req_ptr = 64'hD0; advance();
    bus.req_valid = 0; bus.flush_req = 1;
    advance();
    bus.req_valid = 1; bus.req_ptr = 64'hE0;
    #1;
    n_vec++;
    if (bus.req_ready !== 1'b0 || bus.comp_start !== 1'b0) begin
      n_err++;
      $display("FAIL flush_block: rdy=%b start=%b, 0/0 required", bus.req_ready, bus.comp_start);
    end
    bus.req_valid = 0;
    bus.comp_done = 1; bus.comp_result = 32'd3; advance();
    bus.comp_result = 32'd0; advance();
    bus.comp_done = 0;
    advance();
    n_vec++;
    if (bus.flush_ack !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_early: ack=%b rv=%b, 0/0 required", bus.flush_ack, bus.rsp_valid);
    end
    bus.flush_req = 0;
    advance();
    n_vec++;
    if (bus.flush_ack !== 1'b1) begin
      n_err++;
      $display("FAIL flush_ack: ack=%b, 1 required", bus.flush_ack);
    end
    advance();
    n_vec++;
    if (bus.flush_ack !== 1'b0) begin
      n_err++;
      $display("FAIL flush_pulse: ack=%b, 0 required", bus.flush_ack);
    end
  endtask

  task automatic test_random();
    bit [31:0] r;
    for (int c = 0; c < 600; c++) begin
      r = $urandom;
      bus.req_valid   = (r[1:0] != 0);
      bus.req_ptr     = {$urandom, $urandom};
      bus.comp_busy   = (r[3:2] == 0);
      bus.comp_done   = (ptr_q.size() != 0) && (r[5:4] != 0);
      bus.comp_result = r[6] ? $urandom : 32'd0;
      bus.rsp_ready   = (r[9:7] > 1);
      if (r[14:10] == 0) bus.flush_req = !bus.flush_req;
      #1;
      model_comb();
      n_vec++;
      if ({bus.req_ready, bus.comp_start, bus.comp_stall} !== {e_ready, e_start, e_stall}
          || bus.comp_lang !== bus.req_ptr) begin
        n_err++;
        $display("FAIL rand_comb c=%0d: rdy/start/stall=%b%b%b lang=%h, %b%b%b lang=%h required",
                 c, bus.req_ready, bus.comp_start, bus.comp_stall, bus.comp_lang,
                 e_ready, e_start, e_stall, bus.req_ptr);
      end
      advance();
      n_vec++;
      if ({bus.rsp_valid, bus.err, bus.flush_ack} !== {m_rv, m_err, m_ack}
          || (m_rv && (bus.rsp_data !== m_rd || bus.rsp_ptr !== m_rp))) begin
        n_err++;
        $display("FAIL rand_rsp c=%0d: rv=%b err=%b ack=%b data=%h ptr=%h, %b %b %b %h %h required",
                 c, bus.rsp_valid, bus.err, bus.flush_ack, bus.rsp_data, bus.rsp_ptr,
                 m_rv, m_err, m_ack, m_rd, m_rp);
      end
`ifdef XML_LANG_DISPATCH_STATS_EN
      n_vec++;
      if (stat_calls !== m_calls || stat_valid !== m_valid) begin
        n_err++;
        $display("FAIL rand_stats c=%0d: calls=%0d valid=%0d, %0d/%0d required",
                 c, stat_calls, stat_valid, m_calls, m_valid);
      end
`endif
    end
    set_idle();
    for (int c = 0; c < 40 && (ptr_q.size() != 0 || m_drain || m_ack || m_rv); c++) begin
      bus.comp_done = (ptr_q.size() != 0); bus.comp_result = 32'd2;
      advance();
    end
    bus.comp_done = 0;
    advance();
  endtask

  task automatic test_spurious();
    bus.comp_done = 1; bus.comp_result = 32'd5;
    advance();
    bus.comp_done = 0;
    n_vec++;
    if (bus.err !== 1'b1 || bus.rsp_ptr !== 64'd0 || bus.rsp_data !== 32'd5 || bus.rsp_valid !== 1'b1) begin
      n_err++;
      $display("FAIL spurious: err=%b ptr=%h data=%h rv=%b, 1/0/5/1 required",
               bus.err, bus.rsp_ptr, bus.rsp_data, bus.rsp_valid);
    end
    repeat (3) advance();
    n_vec++;
    if (bus.err !== 1'b1) begin
      n_err++;
      $display("FAIL spurious_sticky: err=%b, 1 required", bus.err);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      bus.req_valid = 1; bus.req_ptr = 64'(32'h200 + i); advance();
    end
    bus.comp_done = 1; bus.comp_result = 32'd1; bus.rsp_ready = 0;
    advance();
    #2;
    resetn = 0;
    model_reset();
    #1;
    n_vec++;
    if ({bus.req_ready, bus.comp_start, bus.comp_stall, bus.rsp_valid, bus.flush_ack, bus.err} !== 6'b0
        || bus.rsp_data !== 32'd0 || bus.rsp_ptr !== 64'd0) begin
      n_err++;
      $display("FAIL reset_mid: rdy=%b start=%b stall=%b rv=%b ack=%b err=%b data=%h ptr=%h, all zero required",
               bus.req_ready, bus.comp_start, bus.comp_stall, bus.rsp_valid, bus.flush_ack, bus.err,
               bus.rsp_data, bus.rsp_ptr);
    end
`ifdef XML_LANG_DISPATCH_STATS_EN
    n_vec++;
    if (stat_calls !== 32'd0 || stat_valid !== 32'd0) begin
      n_err++;
      $display("FAIL reset_mid_stats: calls=%0d valid=%0d, 0/0 required", stat_calls, stat_valid);
    end
`endif
    @(posedge clock);
    #1;
    set_idle();
    resetn = 1;
    bus.comp_done = 1; bus.comp_result = 32'd4;
    advance();
    bus.comp_done = 0;
    n_vec++;
    if (bus.err !== 1'b1 || bus.rsp_ptr !== 64'd0) begin
      n_err++;
      $display("FAIL reset_orphan: err=%b ptr=%h, 1/0 required", bus.err, bus.rsp_ptr);
    end
  endtask

  initial begin
    test_reset();
    test_single_call();
    test_ordering();
    test_backpressure();
    test_flush();
    test_random();
    test_spurious();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
